ofm_accum_stream: RTL



---
 rtl/ofm_accum_stream.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ofm_accum_stream.sv
// ofm_accum_stream: OFM accumulation store filled by PE lanes and drained as packed AXI4-Stream beats
module ofm_accum_stream #(
    parameter int N_LANES = 5,
    parameter int DW      = 8,
    parameter int DEPTH   = 2304,
    parameter int PACK    = 4,
    parameter int SAT     = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic [N_LANES*DW-1:0]  in_data,
    input  logic                   in_first,
    input  logic                   start_drain,
    output logic                   busy,
    output logic                   drain_done,
    output logic                   err_drop,
    output logic                   m_axis_tvalid,
    output logic [PACK*DW-1:0]     m_axis_tdata,
    output logic [PACK*DW/8-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready
);
    localparam int NB = (DEPTH + PACK - 1) / PACK;
    localparam int AW = $clog2(DEPTH + N_LANES);
    localparam int BW = $clog2(NB + 1);
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KB = DW / 8;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t state_q, state_d;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] iss_q, iss_d;
    logic rd_v_q, rd_v_d, rd_last_q;
    logic [PACK*DW-1:0] rd_data_q, rd_data_d;
    logic [PACK*KB-1:0] rd_keep_q, rd_keep_d;
    logic tvalid_q, tvalid_d, tlast_q, err_q;
    logic [PACK*DW-1:0] tdata_q;
    logic [PACK*KB-1:0] tkeep_q;
    logic [N_LANES-1:0] wen;
    logic [MW-1:0] waddr [N_LANES];
    logic [DW-1:0] wval [N_LANES];
    logic wr_go, out_load, issue, last_acc;

    function automatic logic [DW-1:0] acc(input logic [DW-1:0] old, input logic [DW-1:0] lane);
        logic [DW:0] sum;
        sum = {1'b0, old} + {1'b0, lane};
        return (SAT != 0 && sum[DW]) ? {DW{1'b1}} : sum[DW-1:0];
    endfunction

    assign wr_go    = state_q == IDLE && in_valid;
    assign out_load = rd_v_q && (!tvalid_q || m_axis_tready);
    assign issue    = state_q == DRAIN && iss_q != BW'(NB) && (!rd_v_q || out_load);
    assign last_acc = tvalid_q && m_axis_tready && tlast_q;
    assign tvalid_d = out_load || (tvalid_q && !m_axis_tready);

    // Per-lane write address and overwrite/accumulate value; lanes past the end are dropped
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            wen[k]   = wr_go && (int'(wr_ptr_q) + k < DEPTH);
            waddr[k] = MW'(int'(wr_ptr_q) + k);
            wval[k]  = in_first ? in_data[k*DW +: DW] : acc(mem[waddr[k]], in_data[k*DW +: DW]);
        end
    end

    // OFM store: no reset, contents survive a reset so a drain can be repeated
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_LANES; k++)
            if (wen[k]) mem[waddr[k]] <= wval[k];
    end

    // Gather one output beat; pixels beyond the store are zeroed and their bytes disabled
    always_comb begin
        for (int j = 0; j < PACK; j++) begin
            rd_keep_d[j*KB +: KB] = {KB{int'(rd_ptr_q) + j < DEPTH}};
            rd_data_d[j*DW +: DW] = (int'(rd_ptr_q) + j < DEPTH) ? mem[MW'(int'(rd_ptr_q) + j)] : '0;
        end
    end

    // Next-state, pointer and read-stage occupancy logic
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        iss_d    = iss_q;
        rd_v_d   = issue ? 1'b1 : (out_load ? 1'b0 : rd_v_q);
        if (wr_go)
            wr_ptr_d = (int'(wr_ptr_q) + N_LANES >= DEPTH) ? '0 : wr_ptr_q + AW'(N_LANES);
        if (issue) begin
            rd_ptr_d = rd_ptr_q + AW'(PACK);
            iss_d    = iss_q + BW'(1);
        end
        case (state_q)
            IDLE: if (start_drain) begin
                state_d  = DRAIN;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                iss_d    = '0;
            end
            DRAIN: if (last_acc) state_d = FLUSH;
            default: state_d = IDLE;
        endcase
    end

    // Control registers, registered read stage and output register with hold-on-stall
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            iss_q     <= '0;
            rd_v_q    <= 1'b0;
            rd_last_q <= 1'b0;
            rd_data_q <= '0;
            rd_keep_q <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            iss_q    <= iss_d;
            rd_v_q   <= rd_v_d;
            tvalid_q <= tvalid_d;
            err_q    <= in_valid && state_q != IDLE;
            if (issue) begin
                rd_data_q <= rd_data_d;
                rd_keep_q <= rd_keep_d;
                rd_last_q <= iss_q == BW'(NB - 1);
            end
            if (out_load) begin
                tdata_q <= rd_data_q;
                tkeep_q <= rd_keep_q;
                tlast_q <= rd_last_q;
            end
        end
    end

    assign busy          = state_q == DRAIN;
    assign drain_done    = state_q == FLUSH;
    assign err_drop      = err_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
endmodule
